ex_mem_stage: RTL

//  EX->MEM boundary of the 64-bit pipeline. Captures the ALU result and zero flag, store data,

---
 rtl/ex_mem_stage.sv | 133 +++++++++++++
 1 files changed

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline boundary: two-entry skid buffer carrying the ALU result, store data,
// branch target, rd, MEM/WB control and the resolved branch-taken bit. Optional macro: EXMEM_STALL_CNT_EN.
module ex_mem_stage #(
   parameter int XLEN       = 64,
   parameter int REG_ADDR_W = 5
`ifdef EXMEM_STALL_CNT_EN
   , parameter int CNT_W    = 32
`endif
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [XLEN-1:0]       alu_result,
   input  logic                  alu_zero,
   input  logic [XLEN-1:0]       rs2_data,
   input  logic [XLEN-1:0]       branch_target,
   input  logic [REG_ADDR_W-1:0] rd,
   input  logic [4:0]            ctrl_in,
   input  logic                  flush,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [XLEN-1:0]       out_alu_result,
   output logic [XLEN-1:0]       out_rs2_data,
   output logic [XLEN-1:0]       out_branch_target,
   output logic [REG_ADDR_W-1:0] out_rd,
   output logic [3:0]            out_ctrl,
   output logic                  pc_src
`ifdef EXMEM_STALL_CNT_EN
   , output logic [CNT_W-1:0]    stall_cycles
`endif
);

   typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

   typedef struct packed {
      logic [XLEN-1:0]       alu;
      logic [XLEN-1:0]       rs2;
      logic [XLEN-1:0]       tgt;
      logic [REG_ADDR_W-1:0] rd;
      logic [3:0]            ctrl;
      logic                  taken;
   } entry_t;

   state_t state_q, state_d;
   entry_t main_q, main_d, skid_q, skid_d;
   entry_t in_entry;
   logic   cap, pop;

   always_comb begin
      in_entry.alu   = alu_result;
      in_entry.rs2   = rs2_data;
      in_entry.tgt   = branch_target;
      in_entry.rd    = rd;
      in_entry.ctrl  = ctrl_in[3:0];
      in_entry.taken = ctrl_in[4] & alu_zero;
   end

   // in_ready depends on registered state only, never on out_ready
   assign in_ready  = !reset && (state_q != FULL);
   assign out_valid = (state_q != EMPTY);
   assign cap       = in_valid & in_ready & !flush;
   assign pop       = out_valid & out_ready;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = EMPTY;
      end else begin
         unique case (state_q)
            EMPTY: if (cap) begin
               main_d  = in_entry;
               state_d = ONE;
            end
            ONE: begin
               if (cap && pop) begin
                  main_d = in_entry;
               end else if (cap) begin
                  skid_d  = in_entry;
                  state_d = FULL;
               end else if (pop) begin
                  state_d = EMPTY;
               end
            end
            FULL: if (pop) begin
               main_d  = skid_q;
               state_d = ONE;
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

   assign out_alu_result    = main_q.alu;
   assign out_rs2_data      = main_q.rs2;
   assign out_branch_target = main_q.tgt;
   assign out_rd            = main_q.rd;
   assign out_ctrl          = main_q.ctrl;
   assign pc_src            = out_valid & main_q.taken;

`ifdef EXMEM_STALL_CNT_EN
   logic [CNT_W-1:0] stall_q, stall_d;

   // Saturating count of cycles MEM holds off a valid bundle; flush leaves it intact
   always_comb begin
      stall_d = stall_q;
      if (out_valid && !out_ready && (stall_q != '1))
         stall_d = stall_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) stall_q <= '0;
      else       stall_q <= stall_d;
   end

   assign stall_cycles = stall_q;
`endif

endmodule
